reg_access_ctrl: RTL
====================

Name: reg_access_ctrl

Overview:
- Sequencer directly upstream of the 16x4-bit register file; the only block that drives its addr, data_in, write_enable and select pins.
- Turns single-beat commands from instruction decode into timed single-port accesses: nibble read/write, register-pair (8-bit) read/write, increment (ISZ/INC) and exchange (XCH).
- Absorbs the register memory's synchronous read latency and returns one response per command over a valid/ready handshake.

Parameters:
- RD_LAT, 1, register memory read latency in cycles after the address edge; legal values 1..2.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_op  in  3  opcode, reg_op_e
- cmd_idx  in  4  register index; bits [3:1] give the pair for 8-bit ops
- cmd_wdata  in  8  write data; only [3:0] used by 4-bit ops
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_data  out  8  read, old or new data
- rsp_zero  out  1  INC result equals 0
- rsp_err  out  1  illegal opcode
- rf_addr  out  4  to register file addr
- rf_wdata  out  4  to register file data_in
- rf_we  out  1  to register file write_enable
- rf_sel  out  1  to register file select (output enable)
- rf_rdata  in  4  from register file data_out; high-Z unless rf_sel=1

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-high. Port names are clock and reset.
- Reset state: FSM in IDLE. rsp_valid, rsp_data, rsp_zero, rsp_err, rf_addr, rf_wdata, rf_we and rf_sel all 0. cmd_ready=0 while reset is high.
- States: IDLE, RD1, RD2, WR1, WR2, RESP.
- rf_* outputs are registered.
- IDLE:
  - cmd_ready=1.
  - Accept on cmd_valid&cmd_ready; latch op, idx and wdata.
  - Next state: WR1 for WR4/WR8; RESP for an illegal op; RD1 otherwise.
- RD1 / RD2 (each RD_LAT+1 cycles, via a 2-bit wait counter):
  - rf_addr is held for the whole state; rf_we=0.
  - rf_sel=1 only in the final cycle; rf_rdata is sampled only at that cycle's edge.
  - RD1 address: idx for RD4, INC and XCH; {idx[3:1],0} for RD8.
  - RD2 exists only for RD8; address {idx[3:1],1}.
- Pair convention: even register is the high nibble. RD8 gives rsp_data={R[2p],R[2p+1]}.
- After RD1:
  - RD4 goes to RESP.
  - RD8 goes to RD2, then RESP.
  - INC and XCH go to WR1.
- WR1 / WR2 (1 cycle each): rf_we=1, rf_sel=0. Write data per op:
  - WR4: R[idx]=wdata[3:0].
  - WR8: WR1 writes R[2p]=wdata[7:4]; WR2 writes R[2p+1]=wdata[3:0].
  - INC: R[idx]=(old+1) mod 16; 4-bit wrap, so F becomes 0.
  - XCH: R[idx]=wdata[3:0].
- RESP:
  - rsp_valid=1; fields held stable until rsp_ready; then IDLE.
  - cmd_ready is 0 outside IDLE; no back-to-back overlap.
  - rsp_data is zero-extended for 4-bit ops: RD4 returns the value; INC returns the new value; XCH returns the old value; WR4/WR8 return 0.
  - rsp_zero=1 only for INC with new value 0.
  - Opcodes 6 and 7: no register-file access; rsp_err=1, rsp_data=0.
- Latency with RD_LAT=1, accept edge = cycle 0, rsp_valid first high at:
  - RD4: cycle 3
  - RD8: cycle 5
  - INC/XCH: cycle 4
  - WR4: cycle 2
  - WR8: cycle 3
- Reset mid-operation: the in-flight command is dropped and no response is issued. rf_we and rf_sel clear asynchronously; a partial WR8 may have written the high nibble only.
- rsp_ready held high in IDLE has no effect.

Optional Feature:
- Macro: REG_ACCESS_TRACE_EN.
- When defined:
  - Adds outputs trace_valid(1), trace_addr(4) and trace_data(4).
  - These pulse one cycle after every rf_we cycle, carrying that write's address and data.
  - Adds a 16-bit saturating write counter on output trace_count.
- When undefined: the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package reg_access_pkg:
  - reg_op_e {OP_RD4=0, OP_WR4=1, OP_RD8=2, OP_WR8=3, OP_INC=4, OP_XCH=5}
  - state enum
  - REG_IDX_W=4, NIBBLE_W=4
- No sub-module; the FSM, wait counter and capture registers stay flat in one module.

Test Plan:
- WR8 cmd_idx=4'h5 (pair 2), wdata=8'hA7, then RD8 idx=4'h4 -> rf writes R4=A then R5=7; rsp_data=8'hA7; rsp_valid at cycle 5 after RD8 accept.
- R9=F, INC idx=9 -> R9=0, rsp_data=8'h00, rsp_zero=1. A second INC gives rsp_data=8'h01, rsp_zero=0.
- R3=6, XCH idx=3 wdata=8'h0C -> rsp_data=8'h06, R3=C confirmed by RD4.
- RD4 with rsp_ready held low 5 cycles -> rsp_valid and data stable throughout; cmd_ready=0 until the cycle after the handshake.
- Opcode 7 -> rsp_err=1, rsp_data=0, rf_we and rf_sel never asserted. Repeat with RD_LAT=2 for RD4: rf_sel high only on the 3rd RD1 cycle.
- Reset asserted in the WR2 cycle of a WR8 -> rf_we drops immediately, no rsp_valid, cmd_ready=1 after reset release, R[2p] holds the new high nibble.

Source files
------------

// File: rtl/reg_access_pkg.sv
// Shared opcode, state and width definitions for the register-file access sequencer.
package reg_access_pkg;

    localparam int REG_IDX_W = 4;
    localparam int NIBBLE_W  = 4;

    typedef enum logic [2:0] {
        OP_RD4 = 3'd0,
        OP_WR4 = 3'd1,
        OP_RD8 = 3'd2,
        OP_WR8 = 3'd3,
        OP_INC = 3'd4,
        OP_XCH = 3'd5
    } reg_op_e;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_RD1  = 3'd1;
    localparam state_t ST_RD2  = 3'd2;
    localparam state_t ST_WR1  = 3'd3;
    localparam state_t ST_WR2  = 3'd4;
    localparam state_t ST_RESP = 3'd5;

    function automatic logic op_illegal(input logic [2:0] op);
        return op > 3'd5;
    endfunction

endpackage

// File: rtl/reg_access_ctrl.sv
// Sequences single-beat register commands into timed 16x4 register-file accesses.
// Optional write trace port enabled by defining REG_ACCESS_TRACE_EN.
module reg_access_ctrl
    import reg_access_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [2:0]           cmd_op,
    input  logic [REG_IDX_W-1:0] cmd_idx,
    input  logic [7:0]           cmd_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [7:0]           rsp_data,
    output logic                 rsp_zero,
    output logic                 rsp_err,
    output logic [REG_IDX_W-1:0] rf_addr,
    output logic [NIBBLE_W-1:0]  rf_wdata,
    output logic                 rf_we,
    output logic                 rf_sel,
    input  logic [NIBBLE_W-1:0]  rf_rdata
`ifdef REG_ACCESS_TRACE_EN
    ,
    output logic                 trace_valid,
    output logic [REG_IDX_W-1:0] trace_addr,
    output logic [NIBBLE_W-1:0]  trace_data,
    output logic [15:0]          trace_count
`endif
);

    localparam logic [1:0] LAT = RD_LAT[1:0];

    state_t                 r_state, w_state_d;
    logic [1:0]             r_wait, w_wait_d;
    logic [2:0]             r_op, w_op;
    logic [REG_IDX_W-1:0]   r_idx, w_idx;
    logic [7:0]             r_wdata, w_wdata;
    logic [7:0]             r_rsp_data;
    logic                   r_rsp_zero, r_rsp_err;
    logic [REG_IDX_W-1:0]   r_rf_addr, w_rf_addr_d;
    logic [NIBBLE_W-1:0]    r_rf_wdata, w_rf_wdata_d;
    logic                   r_rf_we, r_rf_sel, w_rf_we_d, w_rf_sel_d;
    logic                   w_accept, w_last_rd;
    logic [NIBBLE_W-1:0]    w_inc;

    assign cmd_ready = (r_state == ST_IDLE) && !reset;
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_last_rd = ((r_state == ST_RD1) || (r_state == ST_RD2)) && (r_wait == LAT);
    assign w_inc     = rf_rdata + 4'd1;

    always_comb begin
        w_state_d = r_state;
        w_wait_d  = 2'd0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (op_illegal(cmd_op)) begin
                        w_state_d = ST_RESP;
                    end else if ((cmd_op == OP_WR4) || (cmd_op == OP_WR8)) begin
                        w_state_d = ST_WR1;
                    end else begin
                        w_state_d = ST_RD1;
                    end
                end
            end
            ST_RD1: begin
                if (!w_last_rd) begin
                    w_wait_d = r_wait + 2'd1;
                end else if (r_op == OP_RD8) begin
                    w_state_d = ST_RD2;
                end else if (r_op == OP_RD4) begin
                    w_state_d = ST_RESP;
                end else begin
                    w_state_d = ST_WR1;
                end
            end
            ST_RD2: begin
                if (!w_last_rd) begin
                    w_wait_d = r_wait + 2'd1;
                end else begin
                    w_state_d = ST_RESP;
                end
            end
            ST_WR1:  w_state_d = (r_op == OP_WR8) ? ST_WR2 : ST_RESP;
            ST_WR2:  w_state_d = ST_RESP;
            ST_RESP: if (rsp_ready) w_state_d = ST_IDLE;
            default: w_state_d = ST_IDLE;
        endcase
    end

    // Register-file pins are registered, so they are derived from the next state/counter.
    always_comb begin
        w_op         = (r_state == ST_IDLE) ? cmd_op : r_op;
        w_idx        = (r_state == ST_IDLE) ? cmd_idx : r_idx;
        w_wdata      = (r_state == ST_IDLE) ? cmd_wdata : r_wdata;
        w_rf_addr_d  = r_rf_addr;
        w_rf_wdata_d = r_rf_wdata;
        w_rf_we_d    = (w_state_d == ST_WR1) || (w_state_d == ST_WR2);
        w_rf_sel_d   = ((w_state_d == ST_RD1) || (w_state_d == ST_RD2)) && (w_wait_d == LAT);
        case (w_state_d)
            ST_RD1: w_rf_addr_d = (w_op == OP_RD8) ? {w_idx[3:1], 1'b0} : w_idx;
            ST_RD2: w_rf_addr_d = {w_idx[3:1], 1'b1};
            ST_WR1: begin
                w_rf_addr_d = (w_op == OP_WR8) ? {w_idx[3:1], 1'b0} : w_idx;
                if (w_op == OP_WR8) begin
                    w_rf_wdata_d = w_wdata[7:4];
                end else if (w_op == OP_INC) begin
                    w_rf_wdata_d = w_inc;
                end else begin
                    w_rf_wdata_d = w_wdata[3:0];
                end
            end
            ST_WR2: begin
                w_rf_addr_d  = {w_idx[3:1], 1'b1};
                w_rf_wdata_d = w_wdata[3:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_wait     <= 2'd0;
            r_op       <= 3'd0;
            r_idx      <= '0;
            r_wdata    <= 8'd0;
            r_rf_addr  <= '0;
            r_rf_wdata <= '0;
            r_rf_we    <= 1'b0;
            r_rf_sel   <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_wait     <= w_wait_d;
            r_rf_addr  <= w_rf_addr_d;
            r_rf_wdata <= w_rf_wdata_d;
            r_rf_we    <= w_rf_we_d;
            r_rf_sel   <= w_rf_sel_d;
            if (w_accept) begin
                r_op    <= cmd_op;
                r_idx   <= cmd_idx;
                r_wdata <= cmd_wdata;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rsp_data <= 8'd0;
            r_rsp_zero <= 1'b0;
            r_rsp_err  <= 1'b0;
        end else if (w_accept) begin
            r_rsp_data <= 8'd0;
            r_rsp_zero <= 1'b0;
            r_rsp_err  <= op_illegal(cmd_op);
        end else if (w_last_rd) begin
            if (r_state == ST_RD2) begin
                r_rsp_data[3:0] <= rf_rdata;
            end else if (r_op == OP_RD8) begin
                r_rsp_data <= {rf_rdata, 4'h0};
            end else if (r_op == OP_INC) begin
                r_rsp_data <= {4'h0, w_inc};
                r_rsp_zero <= (w_inc == 4'h0);
            end else begin
                r_rsp_data <= {4'h0, rf_rdata};
            end
        end
    end

    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_data  = r_rsp_data;
    assign rsp_zero  = r_rsp_zero;
    assign rsp_err   = r_rsp_err;
    assign rf_addr   = r_rf_addr;
    assign rf_wdata  = r_rf_wdata;
    assign rf_we     = r_rf_we;
    assign rf_sel    = r_rf_sel;

`ifdef REG_ACCESS_TRACE_EN
    logic                 r_trace_valid;
    logic [REG_IDX_W-1:0] r_trace_addr;
    logic [NIBBLE_W-1:0]  r_trace_data;
    logic [15:0]          r_trace_count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_trace_valid <= 1'b0;
            r_trace_addr  <= '0;
            r_trace_data  <= '0;
            r_trace_count <= 16'd0;
        end else begin
            r_trace_valid <= r_rf_we;
            r_trace_addr  <= r_rf_addr;
            r_trace_data  <= r_rf_wdata;
            if (r_rf_we && (r_trace_count != 16'hFFFF)) begin
                r_trace_count <= r_trace_count + 16'd1;
            end
        end
    end

    assign trace_valid = r_trace_valid;
    assign trace_addr  = r_trace_addr;
    assign trace_data  = r_trace_data;
    assign trace_count = r_trace_count;
`endif

endmodule
